// File: rtl/zero_extender.sv
// Registered zero extender: keeps In[MSB:0], clears the upper bits,
// and presents the result one cycle after each accepted input.
module zero_extender #(
    parameter int MSB   = 3,
    parameter int WIDTH = 16
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In,
    input  logic             InValid,
    output logic [WIDTH-1:0] Out,
    output logic             OutValid
);

    generate
        if (MSB < 0 || MSB >= WIDTH) begin : g_bad_msb
            $error("zero_extender: MSB must lie in 0..WIDTH-1");
        end
    endgenerate

    // Shifting all-ones right keeps MSB == WIDTH-1 a plain pass-through.
    localparam logic [WIDTH-1:0] MASK = {WIDTH{1'b1}} >> (WIDTH - 1 - MSB);

    logic [WIDTH-1:0] result;

    always_comb begin
        result = In & MASK;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            Out      <= '0;
            OutValid <= 1'b0;
        end else begin
            OutValid <= InValid;
            if (InValid) begin
                Out <= result;
            end
        end
    end

endmodule

// File: tb/tb_zero_extender.sv
// Directed bench for zero_extender at MSB = 3, 7, 10 and 15,
// with every instance sharing the same stimulus.
module tb_zero_extender;

    logic        Clk;
    logic        Reset;
    logic [15:0] In;
    logic        InValid;

    logic [15:0] o3, o7, o10, o15;
    logic        v3, v7, v10, v15;

    int compared   = 0;
    int mismatched = 0;

    zero_extender #(.MSB(3), .WIDTH(16)) d3 (
        .Clk(Clk), .Reset(Reset), .In(In), .InValid(InValid),
        .Out(o3), .OutValid(v3)
    );
    zero_extender #(.MSB(7), .WIDTH(16)) d7 (
        .Clk(Clk), .Reset(Reset), .In(In), .InValid(InValid),
        .Out(o7), .OutValid(v7)
    );
    zero_extender #(.MSB(10), .WIDTH(16)) d10 (
        .Clk(Clk), .Reset(Reset), .In(In), .InValid(InValid),
        .Out(o10), .OutValid(v10)
    );
    zero_extender #(.MSB(15), .WIDTH(16)) d15 (
        .Clk(Clk), .Reset(Reset), .In(In), .InValid(InValid),
        .Out(o15), .OutValid(v15)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        compared++;
        assert (obs === exp)
        else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic rst, input logic vld,
                        input logic [15:0] din);
        Reset   = rst;
        InValid = vld;
        In      = din;
        @(posedge Clk);
        #1;
    endtask

    task automatic chk_all(input string tag,
                           input logic [15:0] e3, input logic [15:0] e7,
                           input logic [15:0] e10, input logic [15:0] e15,
                           input logic ev);
        chk({tag, "/o3"},  o3,  e3);
        chk({tag, "/o7"},  o7,  e7);
        chk({tag, "/o10"}, o10, e10);
        chk({tag, "/o15"}, o15, e15);
        chk({tag, "/v3"},  {15'd0, v3},  {15'd0, ev});
        chk({tag, "/v7"},  {15'd0, v7},  {15'd0, ev});
        chk({tag, "/v10"}, {15'd0, v10}, {15'd0, ev});
        chk({tag, "/v15"}, {15'd0, v15}, {15'd0, ev});
    endtask

    initial begin
        Reset   = 1'b1;
        InValid = 1'b0;
        In      = 16'h0000;

        step(1'b1, 1'b0, 16'h0000);
        step(1'b1, 1'b0, 16'h0000);
        chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);

        step(1'b0, 1'b1, 16'hFFFF);
        chk_all("ones", 16'h000F, 16'h00FF, 16'h07FF, 16'hFFFF, 1'b1);

        step(1'b0, 1'b1, 16'hA5C3);
        chk_all("a5c3", 16'h0003, 16'h00C3, 16'h05C3, 16'hA5C3, 1'b1);

        step(1'b0, 1'b1, 16'h0005);
        chk_all("cap5", 16'h0005, 16'h0005, 16'h0005, 16'h0005, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 1'b0, 16'hFFFF);
            chk_all("hold", 16'h0005, 16'h0005, 16'h0005, 16'h0005, 1'b0);
        end

        step(1'b1, 1'b1, 16'h000F);
        chk_all("rst_pri", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'h000F);
        chk_all("post_rst", 16'h000F, 16'h000F, 16'h000F, 16'h000F, 1'b1);

        step(1'b0, 1'b1, 16'h1234);
        chk_all("s1234", 16'h0004, 16'h0034, 16'h0234, 16'h1234, 1'b1);
        step(1'b0, 1'b1, 16'h5678);
        chk_all("s5678", 16'h0008, 16'h0078, 16'h0678, 16'h5678, 1'b1);
        step(1'b1, 1'b1, 16'h9ABC);
        chk_all("mid_rst", 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0);
        step(1'b0, 1'b1, 16'hDEF0);
        chk_all("sdef0", 16'h0000, 16'h00F0, 16'h06F0, 16'hDEF0, 1'b1);
        step(1'b0, 1'b0, 16'h0000);
        chk_all("idle", 16'h0000, 16'h00F0, 16'h06F0, 16'hDEF0, 1'b0);

        for (int i = 0; i < 65536; i++) begin
            logic [15:0] w;
            w = 16'(i);
            step(1'b0, 1'b1, w);
            chk("sweep/o3",  o3,  w & 16'h000F);
            chk("sweep/o7",  o7,  w & 16'h00FF);
            chk("sweep/o10", o10, w & 16'h07FF);
            chk("sweep/o15", o15, w);
            chk("sweep/v",   {12'd0, v3, v7, v10, v15}, 16'h000F);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
